// File: rtl/s_mem_arbiter.sv
// Round-robin arbiter sharing one single-port S-memory between the sequencing FSMs.
// The owner keeps its grant until it drops req; read strobes track the 1-cycle memory latency.
module s_mem_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ-1:0]          req_wr_en,
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]         rd_data,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q
);

  // state | meaning
  // IDLE  | no owner, gnt is zero
  // OWNED | r_owner holds the grant until it drops its req
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           r_state, w_state_nxt;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [OW-1:0]    r_last, w_last_nxt;
  logic [OW-1:0]    w_base, w_winner;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_rd_valid, w_rd_valid_nxt;
  logic [N_REQ-1:0] w_cand;
  logic             w_found;
  logic             w_active;

  assign w_active = r_gnt[r_owner] & req[r_owner];

  // On release the search starts after the outgoing owner, which becomes the new last pointer.
  always_comb begin
    w_base = (r_state == OWNED) ? r_owner : r_last;
    w_cand = req;
    if (r_state == OWNED) w_cand[r_owner] = 1'b0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && w_cand[(int'(w_base) + k) % N_REQ]) begin
        w_found  = 1'b1;
        w_winner = OW'((int'(w_base) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt          = OWNED;
          w_owner_nxt          = w_winner;
          w_gnt_nxt[w_winner]  = 1'b1;
        end
      end
      OWNED: begin
        if (!req[r_owner]) begin
          w_last_nxt = r_owner;
          w_gnt_nxt  = '0;
          if (w_found) begin
            w_owner_nxt         = w_winner;
            w_gnt_nxt[w_winner] = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rd_valid_nxt = '0;
    if (w_active && !req_wr_en[r_owner]) w_rd_valid_nxt[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= OW'(N_REQ - 1);
      r_gnt      <= '0;
      r_rd_valid <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  // Gating by the live grant makes the port go quiet the instant reset asserts.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (w_active) begin
      mem_addr  = req_addr[int'(r_owner)*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[int'(r_owner)*DATA_W +: DATA_W];
      mem_wren  = req_wr_en[r_owner];
    end
  end

  assign gnt      = r_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_data  = mem_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed bench for s_mem_arbiter with a 256x8 registered-address memory model.
// Covers reset, fill/readback, round-robin handoff, ownership hold, release-cycle read and isolation.
module tb_s_mem_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_wr_en;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       rd_data;
  logic [N_REQ-1:0]        rd_valid;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_wren;
  logic [DATA_W-1:0]       mem_q;

  logic [7:0] mem [0:255];
  logic [7:0] r_maddr;

  int n_checks = 0;
  int n_errors = 0;

  s_mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wr_en(req_wr_en), .gnt(gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    r_maddr <= mem_addr;
  end
  assign mem_q = mem[r_maddr];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [7:0] d, input logic we);
    req[i]              = v;
    req_addr[i*8 +: 8]  = a;
    req_wdata[i*8 +: 8] = d;
    req_wr_en[i]        = we;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order [4];
    int w;
    order = '{0, 1, 2, 0};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    r_maddr   = 8'h00;
    rst_n     = 1'b0;
    req       = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wr_en = '0;

    // reset state and reset in the middle of a write
    tick(); tick();
    check_eq("rst_gnt",  32'(gnt), 0);
    check_eq("rst_rdv",  32'(rd_valid), 0);
    check_eq("rst_wren", 32'(mem_wren), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    set_req(1, 1'b1, 8'h33, 8'h77, 1'b1);
    tick();
    check_eq("r1_gnt",  32'(gnt), 'h2);
    check_eq("r1_wren", 32'(mem_wren), 1);
    check_eq("r1_addr", 32'(mem_addr), 'h33);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_gnt",  32'(gnt), 0);
    check_eq("async_wren", 32'(mem_wren), 0);
    check_eq("async_rdv",  32'(rd_valid), 0);
    set_req(0, 1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rel_gnt_pre", 32'(gnt), 0);
    tick();
    check_eq("rel_first_gnt", 32'(gnt), 'h1);
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h33, 8'h77, 1'b0);
    tick();
    check_eq("rel_idle", 32'(gnt), 0);
    check_eq("rst_write_dropped", 32'(mem[8'h33]), 0);

    // init fill by requester 0, then readback
    set_req(0, 1'b1, 8'h00, 8'h00, 1'b1);
    tick();
    check_eq("fill_gnt", 32'(gnt), 'h1);
    for (int a = 0; a < 256; a++) begin
      set_req(0, 1'b1, 8'(a), 8'(a), 1'b1);
      tick();
    end
    set_req(0, 1'b1, 8'h10, 8'h00, 1'b0);
    tick();
    check_eq("rd10_rdv",  32'(rd_valid), 'h1);
    check_eq("rd10_data", 32'(rd_data), 'h10);
    set_req(0, 1'b1, 8'hFF, 8'h00, 1'b0);
    tick();
    check_eq("rdff_rdv",  32'(rd_valid), 'h1);
    check_eq("rdff_data", 32'(rd_data), 'hFF);
    set_req(0, 1'b1, 8'h20, 8'h5A, 1'b1);
    tick();
    check_eq("wr_no_rdv", 32'(rd_valid), 0);
    set_req(0, 1'b1, 8'h20, 8'h00, 1'b0);
    tick();
    check_eq("raw_rdv",  32'(rd_valid), 'h1);
    check_eq("raw_data", 32'(rd_data), 'h5A);
    set_req(0, 1'b0, 8'h20, 8'h00, 1'b0);
    tick();
    check_eq("fill_idle",  32'(gnt), 0);
    check_eq("fill_rdv_0", 32'(rd_valid), 0);

    // all requesting from reset, each holding 4 cycles
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 8'(16 * (i + 1)), 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = order[k];
      tick();
      check_eq("rr_gnt", 32'(gnt), 32'(1 << w));
      if (k == 1) set_req(0, 1'b1, 8'h10, 8'h00, 1'b0);
      for (int c = 0; c < 3; c++) begin
        tick();
        check_eq("rr_hold", 32'(gnt), 32'(1 << w));
      end
      set_req(w, 1'b0, 8'(16 * (w + 1)), 8'h00, 1'b0);
      #1;
      check_eq("rr_rel_addr", 32'(mem_addr), 0);
    end
    tick();
    check_eq("rr_idle", 32'(gnt), 0);

    // ownership hold, read in last active cycle, isolation of a non-owner write
    set_req(1, 1'b1, 8'h10, 8'h00, 1'b0);
    tick();
    check_eq("own_gnt", 32'(gnt), 'h2);
    set_req(0, 1'b1, 8'h20, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h55, 8'hAA, 1'b1);
    #1;
    check_eq("iso_wren_hold", 32'(mem_wren), 0);
    check_eq("own_addr", 32'(mem_addr), 'h10);
    for (int c = 2; c <= 10; c++) begin
      tick();
      check_eq("own_hold", 32'(gnt), 'h2);
    end
    set_req(1, 1'b1, 8'h55, 8'h00, 1'b0);
    tick();
    check_eq("relrd_rdv",  32'(rd_valid), 'h2);
    check_eq("relrd_data", 32'(rd_data), 'h55);
    set_req(1, 1'b0, 8'h55, 8'h00, 1'b0);
    #1;
    check_eq("iso_wren_rel", 32'(mem_wren), 0);
    check_eq("relcyc_gnt",   32'(gnt), 'h2);
    tick();
    check_eq("rr_after1", 32'(gnt), 'h4);
    check_eq("rr_after1_rdv", 32'(rd_valid), 0);
    check_eq("own2_wren",  32'(mem_wren), 1);
    check_eq("own2_wdata", 32'(mem_wdata), 'hAA);
    tick();
    set_req(2, 1'b1, 8'h55, 8'h00, 1'b0);
    tick();
    check_eq("own2_rdv",  32'(rd_valid), 'h4);
    check_eq("own2_data", 32'(rd_data), 'hAA);
    set_req(2, 1'b0, 8'h55, 8'h00, 1'b0);
    tick();
    check_eq("rr_after2", 32'(gnt), 'h1);
    set_req(0, 1'b0, 8'h20, 8'h00, 1'b0);
    tick();
    check_eq("end_idle", 32'(gnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/s_mem_arbiter.md
# s_mem_arbiter

- Shares the single-port 256x8 S-memory between up to N_REQ sequencing FSMs, e.g. init, key-schedule shuffle and decrypt.
- Grants are round-robin and held by the owner until it releases.
- Muxes the owner's address, write data and write enable onto the memory port.
- Returns read data with a per-requester valid strobe aligned to the memory's 1-cycle read latency.

## Interface
- N_REQ, 3, number of requesters; requester 0 has first priority out of reset.
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester access request, level, held for the whole transaction.
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  flattened write data, sliced the same way.
- req_wr_en  in  N_REQ  per-requester write enable; 0 means read.
- gnt  out  N_REQ  one-hot (or zero) grant, registered.
- rd_data  out  DATA_W  read data, broadcast to all requesters; equals mem_q.
- rd_valid  out  N_REQ  one-hot, registered; rd_data is valid for requester i this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wren  out  1  memory write enable.
- mem_q  in  DATA_W  memory read data; registered address, unregistered output, valid 1 cycle after address.

## Operation
States:
- IDLE: no owner.
- OWNED: owner index held in a register.

Registers:
- gnt, owner, last-owner pointer `last`, rd_valid.

Reset (async, on rst_n low):
- state=IDLE, gnt=0, rd_valid=0, last=N_REQ-1.
- Memory port outputs go to 0 immediately because they are gated by gnt.

IDLE:
- If any req bit is set, select the winner by round-robin: search last+1, last+2, ..., wrapping modulo N_REQ, last owner searched last.
- At the next edge, register owner=winner and gnt=onehot(winner), then enter OWNED.
- If no req bit is set, stay in IDLE with gnt=0.

OWNED, req[owner]=1:
- Hold the grant, regardless of other requests.

OWNED, req[owner]=0 (release):
- Set last=owner.
- Run round-robin over req, excluding the owner.
- If a winner exists, gnt moves directly to it at the next edge with no idle cycle; stay in OWNED.
- Otherwise return to IDLE with gnt=0.

Port mux (combinational):
- active = gnt[owner] & req[owner].
- When active: mem_addr, mem_wdata = owner's slices; mem_wren = req_wr_en[owner].
- Otherwise: mem_addr=0, mem_wdata=0, mem_wren=0.
- Signals from non-owners never reach the port.

Read strobe:
- rd_valid[i] <= active & (owner==i) & ~req_wr_en[i].
- The strobe is 1 cycle wide per read cycle. It is independent of later grant changes, so a read issued in the owner's last active cycle still returns.

## Timing
- Grant latency: req rising before edge E in IDLE gives gnt high after E; minimum 1 cycle.
- Handoff: release sampled at edge E; old gnt drops and new gnt rises on the same edge E.
- Write: committed at the edge that ends a cycle with active=1 and req_wr_en=1; one write per cycle.
- Read: address presented in cycle t; rd_valid[i]=1 and rd_data=mem[addr] in cycle t+1. Back-to-back reads give one result per cycle.
- Read after write to the same address: the read data returns the new value.
- Release cycle: a requester that drops req gets no port access in that cycle, even though gnt is still high.
- Simultaneous requests from IDLE: the winner is picked by round-robin; ties never produce multiple grants.
- gnt is always one-hot or zero.
- Reset mid-transaction: any in-flight write on the current cycle is dropped, since mem_wren is forced to 0 immediately, and rd_valid clears. After rst_n rises, the first grant goes to requester 0 if it is requesting.

## Test plan
1. Reset: assert rst_n low while requester 1 is writing -> gnt=0, mem_wren=0, rd_valid=0 asynchronously; after release with req=3'b011 -> gnt=3'b001 one cycle later.
2. Init fill: requester 0 writes data=addr for addr 0x00..0xFF, then reads 0x10 and 0xFF -> rd_valid[0] pulses one cycle after each address with rd_data=0x10 and 0xFF.
3. All requests held from reset, each releasing after 4 cycles -> grant order 0,1,2,0 with direct handoffs and no IDLE cycles.
4. Ownership:
   - Requester 1 owns for 10 cycles while req0 and req2 are asserted -> neither granted until req1 drops.
   - Then gnt=3'b100, not 3'b001 (round-robin after owner 1).
5. Read at release: requester 1 reads 0x55 in its last active cycle and drops req -> next cycle rd_valid=3'b010 with rd_data=mem[0x55], while gnt moves to 2.
6. Isolation: requester 2 drives wr_en=1, addr=0x55, data=0xAA without a grant -> mem_wren stays 0; a later read of 0x55 by the owner returns the original value.
